// File: rtl/bresenham_line_engine.sv
// bresenham_line_engine: latches one line request and walks it with integer Bresenham,
// one pixel per valid/ready beat. Define BLA_PIXCNT_EN to add the pixel_cnt port.
module bresenham_line_engine #(
   parameter int COORD_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               draw_en,
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] y0,
   input  logic [COORD_W-1:0] x1,
   input  logic [COORD_W-1:0] y1,
   input  logic               pixel_ready,
   output logic               pixel_valid,
   output logic [COORD_W-1:0] pixel_x,
   output logic [COORD_W-1:0] pixel_y,
   output logic               draw_done,
   output logic               busy
`ifdef BLA_PIXCNT_EN
   ,
   output logic [COORD_W:0]   pixel_cnt
`endif
);

   localparam int EW = COORD_W + 3;
   localparam logic [COORD_W-1:0] C_ONE = COORD_W'(1);

   typedef enum logic [2:0] {IDLE, SETUP, DRAW, DONE, REARM} state_t;

   typedef struct packed {
      logic [COORD_W-1:0] x0;
      logic [COORD_W-1:0] y0;
      logic [COORD_W-1:0] x1;
      logic [COORD_W-1:0] y1;
   } line_req_t;

   state_t            state_q, state_d;
   line_req_t         req_q;
   logic [COORD_W-1:0] x_q, y_q;
   logic signed [EW-1:0] err_q, dx_q, dy_q;
   logic              sx_neg_q, sy_neg_q;

   logic [COORD_W-1:0] adx, ady;
   logic signed [EW-1:0] dx_s, dy_s, e2, err_nxt;
   logic              beat, at_end, step_x, step_y;

   assign beat   = (state_q == DRAW) && pixel_ready;
   assign at_end = (x_q == req_q.x1) && (y_q == req_q.y1);

   // Setup-time deltas, taken from the latched request only
   always_comb begin
      adx  = (req_q.x1 >= req_q.x0) ? (req_q.x1 - req_q.x0) : (req_q.x0 - req_q.x1);
      ady  = (req_q.y1 >= req_q.y0) ? (req_q.y1 - req_q.y0) : (req_q.y0 - req_q.y1);
      dx_s = signed'({3'b000, adx});
      dy_s = -signed'({3'b000, ady});
   end

   // Both axis decisions look at the old err; a diagonal step applies both terms
   always_comb begin
      e2      = err_q <<< 1;
      step_x  = (e2 >= dy_q);
      step_y  = (e2 <= dx_q);
      err_nxt = err_q;
      if (step_x) err_nxt = err_nxt + dy_q;
      if (step_y) err_nxt = err_nxt + dx_q;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (draw_en) state_d = SETUP;
         SETUP:   state_d = draw_en ? DRAW : IDLE;
         DRAW: begin
            if (!draw_en)              state_d = IDLE;
            else if (beat && at_end)   state_d = DONE;
         end
         DONE:    state_d = REARM;
         REARM:   if (!draw_en) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         err_q    <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
         sx_neg_q <= 1'b0;
         sy_neg_q <= 1'b0;
      end else begin
         if (state_q == IDLE && draw_en)
            req_q <= '{x0: x0, y0: y0, x1: x1, y1: y1};
         if (state_q == SETUP) begin
            dx_q     <= dx_s;
            dy_q     <= dy_s;
            err_q    <= dx_s + dy_s;
            x_q      <= req_q.x0;
            y_q      <= req_q.y0;
            sx_neg_q <= !(req_q.x0 < req_q.x1);
            sy_neg_q <= !(req_q.y0 < req_q.y1);
         end else if (beat && !at_end) begin
            err_q <= err_nxt;
            if (step_x) x_q <= sx_neg_q ? (x_q - C_ONE) : (x_q + C_ONE);
            if (step_y) y_q <= sy_neg_q ? (y_q - C_ONE) : (y_q + C_ONE);
         end
      end
   end

`ifdef BLA_PIXCNT_EN
   localparam logic [COORD_W:0] N_ONE = (COORD_W+1)'(1);
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  pixel_cnt <= '0;
      else if (state_q == SETUP) pixel_cnt <= '0;
      else if (beat)            pixel_cnt <= pixel_cnt + N_ONE;
   end
`endif

   assign pixel_valid = (state_q == DRAW);
   assign draw_done   = (state_q == DONE);
   assign busy        = (state_q == SETUP) || (state_q == DRAW) || (state_q == DONE);
   assign pixel_x     = x_q;
   assign pixel_y     = y_q;

endmodule

// File: tb/tb_bresenham_line_engine.sv
// Bench for bresenham_line_engine: directed lines plus randomized lines, backpressure
// and aborts, checked every cycle against a queue-based line model.
module tb_bresenham_line_engine;
   localparam int W = 8;

   logic         clk = 1'b0, rst = 1'b0, draw_en = 1'b0, pixel_ready = 1'b0;
   logic [W-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
   logic         pixel_valid, draw_done, busy;
   logic [W-1:0] pixel_x, pixel_y;
`ifdef BLA_PIXCNT_EN
   logic [W:0]   pixel_cnt;
`endif

   int n_tests = 0, n_fail = 0;

   // model state: cycle index, expected pixel queue, line timestamps
   int cyc = 0, m_req = -100, m_done = -100, m_len = 0, m_acc = 0;
   bit m_idle = 1, m_active = 0, m_rearm = 0;
   int q_x[$], q_y[$], lx[$], ly[$];
   int done_pulses = 0, hold_cnt = 0, rdy_mode = 0, stall = 0;

   always #5 clk = ~clk;

   bresenham_line_engine #(.COORD_W(W)) dut (
      .clk(clk), .rst(rst), .draw_en(draw_en),
      .x0(x0), .y0(y0), .x1(x1), .y1(y1),
      .pixel_ready(pixel_ready), .pixel_valid(pixel_valid),
      .pixel_x(pixel_x), .pixel_y(pixel_y),
      .draw_done(draw_done), .busy(busy)
`ifdef BLA_PIXCNT_EN
      , .pixel_cnt(pixel_cnt)
`endif
   );

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic void build(input int ax, input int ay, input int bx, input int by);
      int dx, dy, sx, sy, err, e2, x, y;
      lx.delete(); ly.delete();
      dx = iabs(bx - ax); dy = -iabs(by - ay);
      sx = (ax < bx) ? 1 : -1; sy = (ay < by) ? 1 : -1;
      err = dx + dy; x = ax; y = ay;
      for (int k = 0; k < 1000; k++) begin
         lx.push_back(x); ly.push_back(y);
         if (x == bx && y == by) break;
         e2 = 2 * err;
         if (e2 >= dy) begin err += dy; x += sx; end
         if (e2 <= dx) begin err += dx; y += sy; end
      end
   endfunction

   task automatic pin(input string n, input int ax, input int ay, input int bx, input int by, input int e[$]);
      build(ax, ay, bx, by);
      chk({n, "_len"}, lx.size(), e.size() / 2);
      for (int k = 0; k < lx.size() && 2*k+1 < e.size(); k++) begin
         chk({n, "_x"}, lx[k], e[2*k]);
         chk({n, "_y"}, ly[k], e[2*k+1]);
      end
   endtask

   function automatic void model_reset();
      m_idle = 1; m_active = 0; m_rearm = 0; m_done = -100; m_req = -100;
      q_x.delete(); q_y.delete();
   endfunction

   // what the engine does at this rising edge, given the inputs now applied
   task automatic model_update();
      bit ev;
      int ax, ay, bx, by;
      ev = m_active && (cyc >= m_req + 2);
      if (rst) model_reset();
      else if (m_idle) begin
         if (draw_en) begin
            ax = int'(x0); ay = int'(y0); bx = int'(x1); by = int'(y1);
            build(ax, ay, bx, by);
            q_x = lx; q_y = ly; m_len = lx.size(); m_acc = 0;
            chk("line_len", m_len, ((iabs(bx-ax) > iabs(by-ay)) ? iabs(bx-ax) : iabs(by-ay)) + 1);
            m_req = cyc; m_active = 1; m_idle = 0;
         end
      end else if (m_active) begin
         if (!draw_en) begin
            m_active = 0; m_idle = 1; q_x.delete(); q_y.delete();
         end else if (ev && pixel_ready) begin
            void'(q_x.pop_front()); void'(q_y.pop_front()); m_acc++;
            if (q_x.size() == 0) begin m_active = 0; m_done = cyc + 1; m_rearm = 1; end
         end
      end else if (m_rearm && cyc > m_done && !draw_en) begin
         m_rearm = 0; m_idle = 1;
      end
      cyc++;
   endtask

   task automatic compare();
      bit ev, ed, eb;
      ev = m_active && (cyc >= m_req + 2) && (q_x.size() > 0);
      ed = (cyc == m_done);
      eb = m_active || ed;
      chk("pixel_valid", pixel_valid, ev);
      chk("draw_done", draw_done, ed);
      chk("busy", busy, eb);
      if (ev) begin
         chk("pixel_x", pixel_x, q_x[0]);
         chk("pixel_y", pixel_y, q_y[0]);
      end
`ifdef BLA_PIXCNT_EN
      if (ed) chk("pixel_cnt", pixel_cnt, m_len);
`endif
      if (draw_done === 1'b1) done_pulses++;
      if (pixel_valid === 1'b1 && pixel_x == 1 && pixel_y == 0) hold_cnt++;
   endtask

   task automatic tick();
      @(posedge clk); model_update();
      @(negedge clk); compare();
      case (rdy_mode)
         0: pixel_ready = 1'b1;
         1: pixel_ready = ($urandom_range(0, 9) < 7);
         default: begin
            if (pixel_valid && pixel_x == 1 && pixel_y == 0 && stall < 3) begin
               pixel_ready = 1'b0; stall++;
            end else pixel_ready = 1'b1;
         end
      endcase
   endtask

   // asynchronous reset asserted between edges; outputs must clear before any edge
   task automatic do_reset();
      #2 rst = 1'b1; draw_en = 1'b0;
      #1;
      chk("rst_valid", pixel_valid, 0);
      chk("rst_done", draw_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_x", pixel_x, 0);
      chk("rst_y", pixel_y, 0);
`ifdef BLA_PIXCNT_EN
      chk("rst_cnt", pixel_cnt, 0);
`endif
      model_reset();
      tick();
      rst = 1'b0;
   endtask

   task automatic run_line(input int ax, input int ay, input int bx, input int by,
                           input int hold_after, input bit scramble, input int abort_pm);
      bit fin = 0;
      int held = 0;
      x0 = W'(ax); y0 = W'(ay); x1 = W'(bx); y1 = W'(by);
      draw_en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (abort_pm == 0 && i == 0) chk("lat_setup_valid", pixel_valid, 0);
         if (abort_pm == 0 && i == 1) begin
            chk("lat_first_valid", pixel_valid, 1);
            chk("lat_first_x", pixel_x, ax);
         end
         if (m_rearm && cyc > m_done) begin
            if (held < hold_after) held++;
            else begin fin = 1; break; end
         end else if (m_idle && !draw_en) begin
            fin = 1; break;
         end
         if (m_active && abort_pm > 0 && $urandom_range(0, 999) < abort_pm) draw_en = 1'b0;
         if (m_active && scramble) begin
            x0 = W'($urandom); y0 = W'($urandom); x1 = W'($urandom); y1 = W'($urandom);
         end
      end
      chk("line_finished", fin, 1);
      draw_en = 1'b0;
      tick(); tick();
   endtask

   initial begin
      int e[$];
      int p0;
      bit ok;

      // model pinned against hand-computed lines
      e = '{0,0, 1,0, 2,0, 3,0};  pin("pin_h", 0, 0, 3, 0, e);
      e = '{5,5, 4,4, 3,3, 2,2};  pin("pin_d", 5, 5, 2, 2, e);
      e = '{0,0, 0,1, 1,2, 1,3};  pin("pin_s", 0, 0, 1, 3, e);
      e = '{7,9};                 pin("pin_pt", 7, 9, 7, 9, e);

      do_reset();
      tick(); tick();

      rdy_mode = 0;
      p0 = done_pulses;
      run_line(0, 0, 3, 0, 0, 0, 0);
      chk("h_done_pulses", done_pulses - p0, 1);
`ifdef BLA_PIXCNT_EN
      chk("h_cnt_lit", pixel_cnt, 4);
`endif
      run_line(5, 5, 2, 2, 0, 0, 0);
      run_line(0, 0, 1, 3, 0, 0, 0);

      // backpressure on (1,0)
      rdy_mode = 2; stall = 0; hold_cnt = 0;
      run_line(0, 0, 3, 0, 0, 0, 0);
      chk("bp_hold", hold_cnt, 4);
      rdy_mode = 0;

      // degenerate point with draw_en held long after completion
      p0 = done_pulses;
      run_line(7, 9, 7, 9, 10, 0, 0);
      chk("pt_done_pulses", done_pulses - p0, 1);
      run_line(2, 3, 6, 1, 0, 0, 0);

      // reset after 20 accepted beats of a long diagonal
      x0 = 0; y0 = 0; x1 = 255; y1 = 255; draw_en = 1'b1;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (m_acc == 20) begin ok = 1; break; end
      end
      chk("long_reached_20", ok, 1);
      do_reset();
      tick();
      run_line(0, 0, 10, 4, 0, 0, 0);

      // abort mid-line
      x0 = 0; y0 = 0; x1 = 50; y1 = 20; draw_en = 1'b1;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (m_acc == 5) begin ok = 1; break; end
      end
      chk("abort_reached_5", ok, 1);
      draw_en = 1'b0;
      p0 = done_pulses;
      tick();
      chk("abort_valid", pixel_valid, 0);
      tick(); tick();
      chk("abort_busy", busy, 0);
      chk("abort_no_done", done_pulses - p0, 0);

      // randomized lines with random backpressure, occasional aborts, endpoint churn
      rdy_mode = 1;
      for (int n = 0; n < 40; n++) begin
         int lim;
         lim = ($urandom_range(0, 1) == 0) ? 15 : 255;
         run_line($urandom_range(0, lim), $urandom_range(0, lim),
                  $urandom_range(0, lim), $urandom_range(0, lim),
                  $urandom_range(0, 3), 1, (n % 5 == 0) ? 20 : 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1);
   end
endmodule
